// File: rtl/lfsr_pkg.sv
// Shared defaults and maximal-length tap masks for the lfsr block.
package lfsr_pkg;

  localparam int          LFSR_WIDTH = 3;
  localparam logic [2:0]  LFSR_TAPS  = 3'b110;
  localparam logic [2:0]  LFSR_SEED  = 3'b001;

  // Bit i set means state bit i feeds the XOR; masks give period 2**w - 1.
  function automatic logic [15:0] max_taps(input int w);
    case (w)
      2:       return 16'b0000_0000_0000_0011;
      3:       return 16'b0000_0000_0000_0110;
      4:       return 16'b0000_0000_0000_1100;
      5:       return 16'b0000_0000_0001_0100;
      6:       return 16'b0000_0000_0011_0000;
      7:       return 16'b0000_0000_0110_0000;
      8:       return 16'b0000_0000_1011_1000;
      9:       return 16'b0000_0001_0001_0000;
      10:      return 16'b0000_0010_0100_0000;
      11:      return 16'b0000_0101_0000_0000;
      12:      return 16'b0000_1000_0010_1001;
      13:      return 16'b0001_0000_0000_1101;
      14:      return 16'b0010_0000_0001_0101;
      15:      return 16'b0110_0000_0000_0000;
      16:      return 16'b1101_0000_0000_1000;
      default: return 16'b0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Feedback parity for the Fibonacci LFSR; with LFSR_LOCKUP_RECOVER_EN it also
// flags the all-zero lockup state.
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] i_state,
`ifdef LFSR_LOCKUP_RECOVER_EN
  output logic             o_lockup,
`endif
  output logic             o_fb
);

  assign o_fb = ^(i_state & TAPS);

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign o_lockup = (i_state == '0);
`endif

endmodule

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR with synchronous re-seed; the state is the output.
// Optional build macro: LFSR_LOCKUP_RECOVER_EN (all-zero state reloads SEED).
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic [WIDTH-1:0] Qs
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;
`ifdef LFSR_LOCKUP_RECOVER_EN
  logic             w_lockup;
`endif

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .i_state  (r_state),
`ifdef LFSR_LOCKUP_RECOVER_EN
    .o_lockup (w_lockup),
`endif
    .o_fb     (w_fb)
  );

  // NOTE: assign the default first so every path drives w_next and no latch is inferred.
  always_comb begin
    w_next = {r_state[WIDTH-2:0], w_fb};
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (w_lockup) w_next = SEED;
`endif
  end

  // NOTE: non-blocking assignment so every reader samples the pre-edge state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_state <= SEED;
    else if (load) r_state <= SEED;
    else           r_state <= w_next;
  end

  assign Qs = r_state;

endmodule

// File: tb/tb_lfsr.sv
// Directed self-checking bench for lfsr: sequence, load, async reset, period.
module tb_lfsr;
  import lfsr_pkg::*;

  localparam logic [15:0] T4_FULL = max_taps(4);
  localparam logic [3:0]  T4      = T4_FULL[3:0];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [2:0] qs;
  logic [2:0] qs_zero;
  logic [3:0] qs4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr u_dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .Qs    (qs)
  );

  lfsr #(.WIDTH(3), .TAPS(3'b110), .SEED(3'b000)) u_zero (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .Qs    (qs_zero)
  );

  lfsr #(.WIDTH(4), .TAPS(T4), .SEED(4'b0001)) u_w4 (
    .clk   (clk),
    .reset (reset),
    .load  (1'b0),
    .Qs    (qs4)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] free_seq [7] = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
  int n;

  initial begin
    // Asynchronous reset, held over two edges, checked between edges too.
    #1 reset = 1'b0;
    #1 check("reset_async", 16'(qs), 16'h1);
    check("zero_seed_reset", 16'(qs_zero), 16'h0);
    check("w4_reset", 16'(qs4), 16'h1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2 check("reset_hold_edge", 16'(qs), 16'h1);
      @(negedge clk);
      check("reset_hold_mid", 16'(qs), 16'h1);
    end

    // Free run over one full period.
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("seq_%0d", i), 16'(qs), 16'(free_seq[i]));
    end
    check("zero_lockup", 16'(qs_zero), 16'h0);

    // Load mid-sequence restarts at SEED.
    for (int i = 0; i < 3; i++) tick();
    check("pre_load", 16'(qs), 16'h3);
    load = 1'b1;
    tick();
    check("load_once", 16'(qs), 16'h1);
    load = 1'b0;
    tick();
    check("after_load", 16'(qs), 16'h2);

    // Load held holds SEED; release resumes.
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("load_hold_%0d", i), 16'(qs), 16'h1);
    end
    load = 1'b0;
    tick();
    check("load_release", 16'(qs), 16'h2);

    // Reset asserted between edges while at 111.
    for (int i = 0; i < 3; i++) tick();
    check("pre_reset", 16'(qs), 16'h7);
    #2 reset = 1'b0;
    #1 check("reset_midcycle", 16'(qs), 16'h1);
    load = 1'b1;
    tick();
    check("reset_over_load", 16'(qs), 16'h1);
    reset = 1'b1;
    load  = 1'b0;
    tick();
    check("reset_release", 16'(qs), 16'h2);
    check("zero_lockup_late", 16'(qs_zero), 16'h0);

    // Period measurement from a fresh reset, bounded.
    reset = 1'b0;
    #1 reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (qs != 3'b001 && n < 12);
    check("period_w3", 16'(n), 16'd7);

    reset = 1'b0;
    #1 reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (qs4 != 4'b0001 && n < 20);
    check("period_w4", 16'(n), 16'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
